// File: rtl/register8_with_msdff_pkg.sv
// register8_with_msdff_pkg: shared constants for the serial-in/parallel-out
// shift register built from master-slave flip-flops.
//   DefaultWidth - default number of stages
//   MinWidth     - smallest legal stage count
//   MaxWidth     - largest legal stage count
package register8_with_msdff_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned MinWidth     = 2;
  localparam int unsigned MaxWidth     = 32;

endpackage

// File: rtl/register8_with_msdff_if.sv
// register8_with_msdff_if: data/control bundle of the shift register.
//   en  - shift enable (1 = shift on rising clk, 0 = hold)
//   ser - serial data in, enters at po[Width-1]
//   po  - parallel output, the current contents of every stage
// Modports: master drives en/ser and observes po; slave is the register side.
interface register8_with_msdff_if
  import register8_with_msdff_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) ();

  logic             en;
  logic             ser;
  logic [Width-1:0] po;

  modport master (output en, output ser, input po);
  modport slave  (input en, input ser, output po);

endinterface

// File: rtl/register8_with_msdff_ms_dff.sv
// ms_dff: master-slave D flip-flop made of two level-sensitive latches.
//   clk - clock; master open while low, slave open while high -> rising-edge capture
//   rst - asynchronous active-high clear of both latches
//   d   - data in
//   q   - data out (slave latch)
module ms_dff
  import register8_with_msdff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic master_q;

  // Master follows d during the low phase and freezes when clk rises.
  always_latch begin
    if (rst) begin
      master_q <= 1'b0;
    end else if (!clk) begin
      master_q <= d;
    end
  end

  // Slave passes the frozen master value through during the high phase, so q
  // only changes just after a rising edge.
  always_latch begin
    if (rst) begin
      q <= 1'b0;
    end else if (clk) begin
      q <= master_q;
    end
  end

endmodule

// File: rtl/register8_with_msdff.sv
// register8_with_msdff: serial-in/parallel-out right-shift register.
// Each stage is an ms_dff; the enable is a 2:1 mux on each stage's d input
// (no clock gating). On a rising edge with en=1: po <= {ser, po[WIDTH-1:1]}.
//   clk    - single clock
//   rst    - asynchronous active-high reset, clears every stage
//   bus_io - slave side of register8_with_msdff_if (en, ser in; po out)
module register8_with_msdff
  import register8_with_msdff_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic                         clk,
  input logic                         rst,
  register8_with_msdff_if.slave       bus_io
);

  if (WIDTH < MinWidth || WIDTH > MaxWidth) begin : g_width_check
    $error("register8_with_msdff: WIDTH out of range");
  end

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] upstream;

  // Bit i takes its neighbour above; the top stage takes ser.
  assign upstream = {bus_io.ser, stage_q[WIDTH-1:1]};
  // Hold recirculates each stage's own output instead of gating the clock.
  assign stage_d  = bus_io.en ? upstream : stage_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    ms_dff u_stage (
      .clk (clk),
      .rst (rst),
      .d   (stage_d[i]),
      .q   (stage_q[i])
    );
  end

  assign bus_io.po = stage_q;

endmodule

// File: tb/tb_register8_with_msdff.sv
module tb_register8_with_msdff;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] model;
  int           vectors;
  int           miscompares;

  register8_with_msdff_if #(.Width(W)) bus ();

  register8_with_msdff #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  task automatic check(input string tag, input logic [W-1:0] exp);
    vectors++;
    assert (bus.po === exp)
    else begin
      miscompares++;
      $error("FAIL %s: po=%h expected=%h", tag, bus.po, exp);
    end
  endtask

  // Rising edge: the reference model samples ser/en/rst at the edge itself.
  task automatic rise(input string tag);
    #2;
    if (rst) model = '0;
    else if (bus.en) model = (model >> 1) | (W'(bus.ser) << (W - 1));
    clk = 1'b1;
    #1;
    check(tag, model);
  endtask

  task automatic fall();
    #4 clk = 1'b0;
    #3;
  endtask

  // Shift in 8 bits, first bit = seq[7]; odd-numbered bits change while clk is high.
  task automatic load(input logic [7:0] seq, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) bus.ser = seq[7-i];
      rise(tag);
      if (i < 7 && (i % 2 == 0)) bus.ser = seq[6-i];
      fall();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model       = '0;
    clk         = 1'b0;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.ser     = 1'b0;

    // Reset with ser=1, en=1 and the clock running.
    #3 rst = 1'b1;
    bus.ser = 1'b1;
    bus.en  = 1'b1;
    #1 check("reset_async", 8'h00);
    for (int i = 0; i < 3; i++) begin
      rise("reset_clocked");
      check("reset_clocked_const", 8'h00);
      fall();
    end
    rst = 1'b0;
    #1 check("reset_release_no_shift", 8'h00);

    // Serial load 1,0,0,1,1,0,0,1 -> 99, then one 0 -> 4C.
    load(8'b1001_1001, "load");
    check("load_99", 8'h99);
    bus.ser = 1'b0;
    rise("shift_0");
    check("shift_4c", 8'h4c);
    fall();

    // Hold for 5 edges with ser toggling, then one enabled edge with ser=1.
    load(8'b1001_1001, "reload");
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ser = 1'(i);
      rise("hold");
      check("hold_99", 8'h99);
      bus.ser = ~bus.ser;
      fall();
    end
    bus.en  = 1'b1;
    bus.ser = 1'b1;
    rise("hold_release");
    check("hold_release_cc", 8'hcc);
    fall();

    // Reset pulse while clk is high, no edge involved.
    load(8'hff, "load_ff");
    check("load_ff_const", 8'hff);
    bus.ser = 1'b0;
    rise("pre_rst");
    #1 rst = 1'b1;
    model = '0;
    #1 check("rst_clk_high", 8'h00);
    rst = 1'b0;
    #1 check("rst_release_clk_high", 8'h00);
    fall();
    bus.ser = 1'b1;
    rise("post_rst_shift");
    check("post_rst_80", 8'h80);
    fall();

    // Sampling: ser toggles while clk stays low, then while clk stays high.
    for (int i = 0; i < 4; i++) begin
      bus.ser = ~bus.ser;
      #1 check("toggle_clk_low", model);
    end
    bus.ser = 1'b0;
    rise("sample_edge");
    check("sample_edge_40", 8'h40);
    for (int i = 0; i < 3; i++) begin
      #1 bus.ser = ~bus.ser;
      check("toggle_clk_high", 8'h40);
    end
    fall();
    check("after_fall_40", 8'h40);

    // Random ser/en with occasional reset against the reference model.
    for (int i = 0; i < 200; i++) begin
      bus.ser = 1'($urandom_range(0, 1));
      bus.en  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        rst   = 1'b1;
        model = '0;
        #1 check("rand_rst", 8'h00);
      end else begin
        rst = 1'b0;
      end
      rise("rand");
      fall();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
